// File: rtl/stack_pkg.sv
// Shared definitions for the 8-queen solver stack controller.
//   - stack_ctrl_state_t : controller FSM state encoding
//   - ERR_* constants    : err_code values reported on a rejected request
//   - DEFAULT_DEPTH/SIZE : default stack geometry, matching the datapath
// Optional feature macro: STACK_CTRL_CLEAR_EN adds the CLEAR state.
package stack_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_SIZE  = 6;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UDF  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP,
`ifdef STACK_CTRL_CLEAR_EN
        S_CLEAR,
`endif
        S_DONE,
        S_ERR
    } stack_ctrl_state_t;

endpackage

// File: rtl/stack_controller_if.sv
// Bundle of every signal between the stack controller, the solver FSM
// (request/done handshake) and the stack datapath (strobes and status).
//   master : solver + datapath side (drives requests, top word, msb/zero)
//   slave  : stack_controller side
// Optional feature macro: STACK_CTRL_CLEAR_EN adds clear_req.
interface stack_controller_if #(
    parameter int SIZE = stack_pkg::DEFAULT_SIZE
);
    // solver handshake
    logic            push_req;
    logic            pop_req;
`ifdef STACK_CTRL_CLEAR_EN
    logic            clear_req;
`endif
    logic            busy;
    logic            done;
    logic            err;
    logic [1:0]      err_code;
    logic [SIZE-1:0] data_out;
    logic            full;
    logic            empty;
    // datapath side
    logic [SIZE-1:0] stack_data;
    logic            msb;
    logic            zero;
    logic            push;
    logic            pop;

    modport master (
        output push_req, pop_req, stack_data, msb, zero,
`ifdef STACK_CTRL_CLEAR_EN
        output clear_req,
`endif
        input  busy, done, err, err_code, data_out, full, empty, push, pop
    );

    modport slave (
        input  push_req, pop_req, stack_data, msb, zero,
`ifdef STACK_CTRL_CLEAR_EN
        input  clear_req,
`endif
        output busy, done, err, err_code, data_out, full, empty, push, pop
    );

endinterface

// File: rtl/stack_controller.sv
// Sequencing FSM between the 8-queen solver control FSM and the stack
// datapath. Turns push/pop (and optional clear) requests into single datapath
// strobes, rejects overflow/underflow/illegal requests, registers the popped
// word and reports done/err back to the solver.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : stack_controller_if.slave (requests, status, strobes, data)
// Optional feature macro: STACK_CTRL_CLEAR_EN enables clear_req / CLEAR,
// a multi-cycle drain that pops until the stack is empty.
module stack_controller
    import stack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SIZE  = DEFAULT_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    stack_controller_if.slave  bus
);

    // The datapath flags full from its counter MSB, which only works for a
    // power-of-two depth.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("stack_controller: DEPTH must be a power of two");
    end

    stack_ctrl_state_t state_q, state_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [SIZE-1:0]   data_out_q, data_out_d;
    logic              push_s;
    logic              pop_s;
    logic              clear_hit;
    logic              clear_last;

`ifdef STACK_CTRL_CLEAR_EN
    // Shadow occupancy count. The datapath only exposes msb/zero, but the
    // drain must know which pop is the last one so that done follows the
    // final strobe directly. The datapath shares reset and only moves on our
    // strobes, so this count cannot drift from it.
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clear_hit  = bus.clear_req;
    assign clear_last = (cnt_q == CNT_W'(1));
`else
    assign clear_hit  = 1'b0;
    assign clear_last = 1'b0;
`endif

    // Next-state, error latch and popped-word capture.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        data_out_d = data_out_q;
        case (state_q)
            S_IDLE: begin
                if (clear_hit) begin
`ifdef STACK_CTRL_CLEAR_EN
                    // An empty stack needs no strobe at all.
                    state_d = bus.zero ? S_DONE : S_CLEAR;
`endif
                end else if (bus.push_req && bus.pop_req) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_ILL;
                end else if (bus.push_req && bus.msb) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_OVF;
                end else if (bus.push_req) begin
                    state_d = S_PUSH;
                end else if (bus.pop_req && bus.zero) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_UDF;
                end else if (bus.pop_req) begin
                    state_d = S_POP;
                end
            end
            S_PUSH: state_d = S_DONE;
            S_POP: begin
                // Captured on the same edge the datapath decrements, while
                // stack_data still shows the old top entry.
                data_out_d = bus.stack_data;
                state_d    = S_DONE;
            end
`ifdef STACK_CTRL_CLEAR_EN
            S_CLEAR: begin
                if (bus.zero || clear_last) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            err_code_q <= ERR_NONE;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            data_out_q <= data_out_d;
        end
    end

    // Strobes decode straight from the state register; push and pop live in
    // disjoint states so they can never overlap.
    always_comb begin
        push_s = (state_q == S_PUSH);
        pop_s  = (state_q == S_POP);
`ifdef STACK_CTRL_CLEAR_EN
        if (state_q == S_CLEAR && !bus.zero) begin
            pop_s = 1'b1;
        end
`endif
    end

    assign bus.push     = push_s;
    assign bus.pop      = pop_s;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = (state_q == S_ERR);
    assign bus.err_code = err_code_q;
    assign bus.data_out = data_out_q;
    assign bus.full     = bus.msb;
    assign bus.empty    = bus.zero;

endmodule

// File: tb/tb_stack_controller.sv
// Directed testbench for stack_controller. A small behavioural stack
// datapath (8 x 6-bit, counter with msb/zero) sits beside the DUT as its
// parent would place it. Inputs change and outputs are checked on the
// falling clock edge.
// Optional feature macro: STACK_CTRL_CLEAR_EN enables the clear tests.
module tb_stack_controller;

    localparam int DEPTH = 8;
    localparam int SIZE  = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_controller_if #(.SIZE(SIZE)) bus ();

    stack_controller #(.DEPTH(DEPTH), .SIZE(SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- behavioural stack datapath ----------------
    logic [SIZE-1:0] mem [DEPTH];
    logic [3:0]      dp_cnt;
    logic [SIZE-1:0] bus_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_cnt <= '0;
        end else if (bus.push) begin
            mem[dp_cnt[2:0]] <= bus_in;
            dp_cnt           <= dp_cnt + 4'd1;
        end else if (bus.pop) begin
            dp_cnt <= dp_cnt - 4'd1;
        end
    end

    logic [3:0] dp_top;
    assign dp_top         = dp_cnt - 4'd1;
    assign bus.stack_data = mem[dp_top[2:0]];
    assign bus.msb        = dp_cnt[3];
    assign bus.zero       = (dp_cnt == 4'd0);

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.push && bus.pop) chk("push_pop_exclusive", 32'd1, 32'd0);
    end

    // ---------------- operations ----------------
    task automatic do_push(input logic [SIZE-1:0] word);
        @(negedge clk);
        bus_in       = word;
        bus.push_req = 1'b1;
        @(negedge clk);                       // cycle N+1
        bus.push_req = 1'b0;
        chk("push_strobe", bus.push, 1);
        chk("push_no_pop", bus.pop, 0);
        @(negedge clk);                       // cycle N+2
        chk("push_done", {bus.done, bus.push}, 2'b10);
        chk("push_not_empty", bus.empty, 0);
        @(negedge clk);                       // cycle N+3
        chk("push_idle", bus.busy, 0);
        $display("push 0x%0h -> done, count now %0d", word, dp_cnt);
    endtask

    task automatic do_pop(input logic [SIZE-1:0] exp_word, input logic exp_empty);
        @(negedge clk);
        bus.pop_req = 1'b1;
        @(negedge clk);
        bus.pop_req = 1'b0;
        chk("pop_strobe", {bus.pop, bus.push}, 2'b10);
        @(negedge clk);
        chk("pop_done", {bus.done, bus.pop}, 2'b10);
        chk("pop_data", bus.data_out, exp_word);
        chk("pop_empty", bus.empty, exp_empty);
        @(negedge clk);
        chk("pop_idle", bus.busy, 0);
        $display("pop -> data_out 0x%0h", bus.data_out);
    endtask

    task automatic do_err(input logic preq, input logic oreq, input logic [1:0] exp_code);
        @(negedge clk);
        bus.push_req = preq;
        bus.pop_req  = oreq;
        @(negedge clk);
        bus.push_req = 1'b0;
        bus.pop_req  = 1'b0;
        chk("err_pulse", {bus.err, bus.done, bus.busy}, 3'b101);
        chk("err_code", bus.err_code, exp_code);
        chk("err_no_strobe", {bus.push, bus.pop}, 2'b00);
        @(negedge clk);
        chk("err_idle", {bus.err, bus.busy}, 2'b00);
        chk("err_code_hold", bus.err_code, exp_code);
        $display("request push=%0b pop=%0b -> err_code %b", preq, oreq, bus.err_code);
    endtask

    initial begin
        reset        = 1'b1;
        bus.push_req = 1'b0;
        bus.pop_req  = 1'b0;
`ifdef STACK_CTRL_CLEAR_EN
        bus.clear_req = 1'b0;
`endif
        bus_in = '0;
        #1;
        chk("rst_strobes", {bus.push, bus.pop}, 2'b00);
        chk("rst_status", {bus.busy, bus.done, bus.err}, 3'b000);
        chk("rst_err_code", bus.err_code, 2'b00);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_full_empty", {bus.full, bus.empty}, 2'b01);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        $display("reset released");

        // basic push then pop of the same word
        do_push(6'h2A);
        do_pop(6'h2A, 1'b1);

        // underflow and illegal requests
        do_err(1'b0, 1'b1, 2'b10);
        do_err(1'b1, 1'b1, 2'b11);

        // fill, then overflow
        for (int i = 0; i < DEPTH; i++) do_push(6'(6'h10 + i));
        chk("fill_full", bus.full, 1);
        do_err(1'b1, 1'b0, 2'b01);
        chk("ovf_still_full", bus.full, 1);

        // LIFO order
        do_pop(6'h17, 1'b0);
        do_pop(6'h16, 1'b0);

        // a request raised while busy is ignored
        @(negedge clk);
        bus.pop_req = 1'b1;
        @(negedge clk);
        bus.pop_req  = 1'b0;
        bus.push_req = 1'b1;
        @(negedge clk);
        bus.push_req = 1'b0;
        chk("busy_ignore_done", bus.done, 1);
        @(negedge clk);
        chk("busy_ignore_idle", {bus.busy, bus.push}, 2'b00);
        chk("busy_ignore_data", bus.data_out, 6'h15);
        chk("busy_ignore_count", dp_cnt, 5);
        $display("pop with push_req raised while busy -> count %0d", dp_cnt);

`ifdef STACK_CTRL_CLEAR_EN
        // drain 5 entries: pop for 5 cycles, done right after
        @(negedge clk);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("clear_pop", {bus.pop, bus.push, bus.done}, 3'b100);
            @(negedge clk);
        end
        chk("clear_done", {bus.done, bus.pop}, 2'b10);
        chk("clear_empty", bus.empty, 1);
        chk("clear_data_hold", bus.data_out, 6'h15);
        @(negedge clk);
        chk("clear_idle", bus.busy, 0);
        $display("clear of 5 entries -> empty=%0b", bus.empty);

        // clear on an empty stack: done straight away, no strobe
        @(negedge clk);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        chk("clear_empty_done", {bus.done, bus.pop}, 2'b10);
        @(negedge clk);
        chk("clear_empty_idle", bus.busy, 0);
        $display("clear of empty stack -> done");
        do_push(6'h05);
`endif

        // reset asserted while the pop strobe is high
        @(negedge clk);
        bus.pop_req = 1'b1;
        @(negedge clk);
        bus.pop_req = 1'b0;
        chk("rst_mid_pop_pre", bus.pop, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_pop", {bus.pop, bus.busy, bus.done}, 3'b000);
        chk("rst_mid_data", bus.data_out, 0);
        chk("rst_mid_empty", bus.empty, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", {bus.busy, bus.push, bus.pop}, 3'b000);
        $display("reset during pop -> aborted, idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
# stack_controller

Sequencing FSM that drives the `push`/`pop` strobes of the 8-queen solver's stack datapath and returns its `msb`/`zero` status as full/empty. It gives the solver FSM a simple request/done handshake, performs overflow, underflow and illegal-request checks, and registers the popped word. Push and pop are single-strobe operations. Clear is an optional multi-cycle drain. The block sits between the solver control FSM and the stack datapath and shares their clock and reset.

## Interface
- `DEPTH`, 8: stack entries; power of two, matching the datapath.
- `SIZE`, 6: stack word width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push_req`  in  1  push request; sampled only in IDLE.
- `pop_req`  in  1  pop request; sampled only in IDLE.
- `clear_req`  in  1  drain request; sampled only in IDLE and present only with `STACK_CTRL_CLEAR_EN`.
- `stack_data`  in  SIZE  datapath top-of-stack word, combinational from the datapath at pointer−1.
- `msb`  in  1  datapath counter MSB; count == DEPTH.
- `zero`  in  1  datapath counter zero; count == 0.
- `push`  out  1  datapath push strobe.
- `pop`  out  1  datapath pop strobe.
- `full`  out  1  equals `msb`; combinational.
- `empty`  out  1  equals `zero`; combinational.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when an operation completes successfully.
- `err`  out  1  one-cycle pulse when a request is rejected.
- `err_code`  out  2  error cause: 01 overflow, 10 underflow, 11 illegal; holds until the next `err`.
- `data_out`  out  SIZE  registered popped word; holds until the next pop.

## Operation
- States: IDLE, PUSH, POP, CLEAR, DONE, ERR.
- IDLE transitions, in priority order:
  - `clear_req` → CLEAR.
  - `push_req` & `pop_req` → ERR with code 11.
  - `push_req` & `msb` → ERR with code 01.
  - `push_req` → PUSH.
  - `pop_req` & `zero` → ERR with code 10.
  - `pop_req` → POP.
- PUSH: `push`=1 for exactly one cycle, so the datapath writes `bus_in` at the push pointer. Next state DONE.
- POP: `pop`=1 for exactly one cycle, and `data_out` ← `stack_data` on the same edge as the counter decrement. Next state DONE.
- CLEAR: `pop`=1 in every cycle where `zero`=0. When `zero`=1, `pop`=0 and next state is DONE. An already-empty stack goes straight to DONE with no strobe. `data_out` is not updated during CLEAR.
- DONE: `done`=1, then IDLE.
- ERR: `err`=1 and `err_code` is latched, then IDLE. No strobe is issued and the stack is unchanged.
- Requests arriving while `busy`=1 are ignored, not queued.
- `push` and `pop` are never both high.

## Timing
- Reset values:
  - state IDLE.
  - `push`, `pop`, `busy`, `done`, `err` = 0.
  - `err_code` = 00, `data_out` = 0.
  - `full`/`empty` track the datapath, which resets to empty.
- Request sampled at edge N:
  - push or pop: strobe high in cycle N+1, `done` in cycle N+2, IDLE again in cycle N+3.
  - error: `err` high in cycle N+1, IDLE in cycle N+2.
- Clear latency: a stack holding k entries gives `pop` high for k cycles starting at N+1, then `done` at N+k+1.
- Requesters drop their request by the `done`/`err` cycle. A request still high in IDLE starts a new operation.
- `full`/`empty` reflect the post-operation count in the `done` cycle.
- Reset asserted mid-operation: outputs return asynchronously to reset values and the operation is aborted. The datapath shares `reset`, so its state stays consistent.

## Configuration
- `STACK_CTRL_CLEAR_EN` defined:
  - the `clear_req` port and the CLEAR state exist.
  - clear has the highest priority in IDLE.
- Not defined:
  - no `clear_req` port and no CLEAR state.
  - IDLE decode is push/pop only; everything else is identical.

## Structure
- Shared package `stack_pkg` holds:
  - the state enum `stack_ctrl_state_t`.
  - the error-code constants `ERR_NONE`, `ERR_OVF`, `ERR_UDF`, `ERR_ILL`.
  - the default `DEPTH` and `SIZE`.
- No sub-module: a single-process FSM plus output and data registers. The datapath is instantiated alongside this block by its parent, not inside it.

## Test plan
- After reset, push_req with stack_data irrelevant → `push`=1 for exactly one cycle at N+1; `done` at N+2; `empty`=0 afterwards.
- Push 8 words, then push_req → `err`=1 with `err_code`=01; no `push` strobe; `full` stays 1.
- Push 0x2A then pop_req → `pop` at N+1; `data_out`=0x2A; `done` at N+2; `empty`=1.
- Pop_req on an empty stack → `err_code`=10; no strobe. Push_req and pop_req in the same cycle → `err_code`=11; no strobe.
- With `STACK_CTRL_CLEAR_EN`: push 3 words, then clear_req → `pop` high for 3 consecutive cycles, `done` at N+4, `empty`=1.
- Assert reset during POP → `pop`, `busy` and `done` are 0 immediately; state is IDLE and `data_out`=0.
